// File: rtl/branch_resolve.sv
// EX-stage branch resolution: computes the architectural next PC, checks it against the
// fetch prediction, and drives redirect/flush sequencing plus predictor-update pulses.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_i,
    input  logic             sl_i,
    input  logic             ul_i,
    input  logic             eq_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_target_i,
    input  logic             redirect_ready_i,
    output logic             busy_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic             upd_valid_o,
    output logic             upd_taken_o,
    output logic [31:0]      upd_pc_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StFlush
    } state_e;

    // Counter stays at least one bit wide so FLUSH_CYCLES of 0 or 1 still elaborates.
    localparam int unsigned FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FlushLoad = FCW'(FLUSH_CYCLES);

    state_e           r_state;
    state_e           w_state_d;
    logic [FCW-1:0]   r_flush_cnt;
    logic [FCW-1:0]   w_flush_cnt_d;
    logic [31:0]      r_redirect_pc;
    logic             r_misalign;
    logic             r_upd_valid;
    logic             r_upd_taken;
    logic [31:0]      r_upd_pc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_br_taken;
    logic             w_taken;
    logic [31:0]      w_pc_sum;
    logic [31:0]      w_rs1_sum;
    logic [31:0]      w_target;
    logic [31:0]      w_fall;
    logic [31:0]      w_next_pc;
    logic             w_misalign;
    logic             w_mispredict;
    logic             w_accept;
    logic             w_start_redirect;

    always_comb begin
        w_br_taken = 1'b0;
        case (funct3_i)
            3'b000:  w_br_taken = eq_i;
            3'b001:  w_br_taken = ~eq_i;
            3'b100:  w_br_taken = sl_i;
            3'b101:  w_br_taken = ~sl_i;
            3'b110:  w_br_taken = ul_i;
            3'b111:  w_br_taken = ~ul_i;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_taken   = is_jal_i | is_jalr_i | w_br_taken;
    assign w_pc_sum  = pc_i + imm_i;
    assign w_rs1_sum = rs1_i + imm_i;
    assign w_target  = is_jalr_i ? {w_rs1_sum[31:1], 1'b0} : w_pc_sum;
    assign w_fall    = pc_i + 32'd4;
    assign w_next_pc = w_taken ? w_target : w_fall;

    assign w_misalign   = w_taken & w_target[1];
    assign w_mispredict = (pred_taken_i != w_taken) |
                          (w_taken & (pred_target_i != w_target));

    assign w_accept         = valid_i & ~stall_i & (r_state == StIdle);
    // Misalignment wins: the instruction traps instead of redirecting.
    assign w_start_redirect = w_accept & w_mispredict & ~w_misalign;

    always_comb begin
        w_state_d     = r_state;
        w_flush_cnt_d = r_flush_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_start_redirect) begin
                    w_state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ready_i) begin
                    if (FLUSH_CYCLES == 0) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d     = StFlush;
                        w_flush_cnt_d = FlushLoad;
                    end
                end
            end
            StFlush: begin
                if (r_flush_cnt <= FCW'(1)) begin
                    w_state_d     = StIdle;
                    w_flush_cnt_d = '0;
                end else begin
                    w_flush_cnt_d = r_flush_cnt - FCW'(1);
                end
            end
            default: begin
                w_state_d     = StIdle;
                w_flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_flush_cnt <= w_flush_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
            r_upd_valid   <= 1'b0;
            r_upd_taken   <= 1'b0;
            r_upd_pc      <= '0;
            r_cnt         <= '0;
        end else begin
            r_upd_valid <= w_accept;
            r_misalign  <= w_accept & w_misalign;
            if (w_accept) begin
                r_upd_taken <= w_taken;
                r_upd_pc    <= pc_i;
            end
            if (w_start_redirect) begin
                r_redirect_pc <= w_next_pc;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy_o           = (r_state != StIdle);
    assign redirect_valid_o = (r_state == StRedirect);
    assign flush_o          = (r_state == StFlush);
    assign redirect_pc_o    = r_redirect_pc;
    assign misalign_o       = r_misalign;
    assign upd_valid_o      = r_upd_valid;
    assign upd_taken_o      = r_upd_taken;
    assign upd_pc_o         = r_upd_pc;
    assign mispredict_cnt_o = r_cnt;

endmodule
